// File: rtl/vga_raster_engine.sv
// Pixel-command engine: turns PLOT / FILL / CLEAR commands into one framebuffer
// write per clock, with rectangle corners normalised and clipped to the screen.
module vga_raster_engine #(
    parameter int H_RES       = 160,
    parameter int V_RES       = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [X_BITS-1:0]      cmd_x0,
    input  logic [Y_BITS-1:0]      cmd_y0,
    input  logic [X_BITS-1:0]      cmd_x1,
    input  logic [Y_BITS-1:0]      cmd_y1,
    input  logic [COLOUR_BITS-1:0] cmd_colour,
    input  logic                   cmd_abort,
    output logic                   plot,
    output logic [X_BITS-1:0]      plot_x,
    output logic [Y_BITS-1:0]      plot_y,
    output logic [COLOUR_BITS-1:0] plot_colour,
    output logic                   busy
);

    localparam logic [1:0] OP_PLOT  = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(H_RES - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(V_RES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic                     plot_reg, plot_next;
    logic [X_BITS-1:0]        plot_x_reg, plot_x_next;
    logic [Y_BITS-1:0]        plot_y_reg, plot_y_next;
    logic [COLOUR_BITS-1:0]   plot_colour_reg, plot_colour_next;
    logic [X_BITS-1:0]        xa_reg, xa_next;
    logic [X_BITS-1:0]        xb_reg, xb_next;
    logic [Y_BITS-1:0]        yb_reg, yb_next;

    // Normalised and clipped rectangle for the command currently on the bus
    logic [X_BITS-1:0] fill_xa, fill_xb, fill_xhi;
    logic [Y_BITS-1:0] fill_ya, fill_yb, fill_yhi;
    logic              fill_ok;
    logic              plot_ok;

    always_comb begin
        fill_xa  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        fill_xhi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        fill_ya  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        fill_yhi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        if (cmd_op == OP_CLEAR) begin
            fill_xa  = '0;
            fill_xhi = X_MAX;
            fill_ya  = '0;
            fill_yhi = Y_MAX;
        end
        fill_xb = (32'(fill_xhi) >= 32'(H_RES)) ? X_MAX : fill_xhi;
        fill_yb = (32'(fill_yhi) >= 32'(V_RES)) ? Y_MAX : fill_yhi;
        fill_ok = (32'(fill_xa) < 32'(H_RES)) && (32'(fill_ya) < 32'(V_RES));
        plot_ok = (32'(cmd_x0) < 32'(H_RES)) && (32'(cmd_y0) < 32'(V_RES));
    end

    // The plot_x/plot_y registers double as the raster walk counters during FILL
    always_comb begin
        state_next       = state_reg;
        plot_next        = 1'b0;
        plot_x_next      = plot_x_reg;
        plot_y_next      = plot_y_reg;
        plot_colour_next = plot_colour_reg;
        xa_next          = xa_reg;
        xb_next          = xb_reg;
        yb_next          = yb_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_PLOT) begin
                        if (plot_ok) begin
                            plot_next        = 1'b1;
                            plot_x_next      = cmd_x0;
                            plot_y_next      = cmd_y0;
                            plot_colour_next = cmd_colour;
                        end
                    end else if ((cmd_op == OP_FILL) || (cmd_op == OP_CLEAR)) begin
                        if (fill_ok) begin
                            state_next       = FILL;
                            plot_next        = 1'b1;
                            plot_x_next      = fill_xa;
                            plot_y_next      = fill_ya;
                            plot_colour_next = cmd_colour;
                            xa_next          = fill_xa;
                            xb_next          = fill_xb;
                            yb_next          = fill_yb;
                        end
                    end
                end
            end
            FILL: begin
                if (cmd_abort) begin
                    state_next = IDLE;
                end else if ((plot_x_reg == xb_reg) && (plot_y_reg == yb_reg)) begin
                    state_next = IDLE;
                end else begin
                    plot_next = 1'b1;
                    if (plot_x_reg == xb_reg) begin
                        plot_x_next = xa_reg;
                        plot_y_next = plot_y_reg + Y_BITS'(1);
                    end else begin
                        plot_x_next = plot_x_reg + X_BITS'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            plot_reg        <= 1'b0;
            plot_x_reg      <= '0;
            plot_y_reg      <= '0;
            plot_colour_reg <= '0;
            xa_reg          <= '0;
            xb_reg          <= '0;
            yb_reg          <= '0;
        end else begin
            state_reg       <= state_next;
            plot_reg        <= plot_next;
            plot_x_reg      <= plot_x_next;
            plot_y_reg      <= plot_y_next;
            plot_colour_reg <= plot_colour_next;
            xa_reg          <= xa_next;
            xb_reg          <= xb_next;
            yb_reg          <= yb_next;
        end
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign busy        = (state_reg == FILL);
    assign plot        = plot_reg;
    assign plot_x      = plot_x_reg;
    assign plot_y      = plot_y_reg;
    assign plot_colour = plot_colour_reg;

endmodule

// File: tb/tb_vga_raster_engine.sv
// Bench for vga_raster_engine: expected pixels are queued as commands are issued
// and popped by a monitor that compares every plot strobe.
module tb_vga_raster_engine;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int XB = 8;
    localparam int YB = 7;
    localparam int CB = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [XB-1:0] cmd_x0 = '0;
    logic [YB-1:0] cmd_y0 = '0;
    logic [XB-1:0] cmd_x1 = '0;
    logic [YB-1:0] cmd_y1 = '0;
    logic [CB-1:0] cmd_colour = '0;
    logic          cmd_abort = 1'b0;
    logic          plot;
    logic [XB-1:0] plot_x;
    logic [YB-1:0] plot_y;
    logic [CB-1:0] plot_colour;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int plot_total = 0;
    int last_x = -1;
    int last_y = -1;
    logic [XB+YB+CB-1:0] exp_q[$];

    vga_raster_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .X_BITS(XB), .Y_BITS(YB), .COLOUR_BITS(CB)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
        .cmd_y1(cmd_y1), .cmd_colour(cmd_colour), .cmd_abort(cmd_abort),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer
    always @(negedge clock) begin
        if (plot === 1'b1) begin
            logic [XB+YB+CB-1:0] exp_pix;
            checks++;
            plot_total++;
            last_x = int'(plot_x);
            last_y = int'(plot_y);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_plot got x=%0d y=%0d c=%h want none", plot_x, plot_y, plot_colour);
            end else begin
                exp_pix = exp_q.pop_front();
                if ({plot_x, plot_y, plot_colour} !== exp_pix)
                begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%h want x=%0d y=%0d c=%h",
                             plot_x, plot_y, plot_colour,
                             exp_pix[XB+YB+CB-1 -: XB], exp_pix[YB+CB-1 -: YB], exp_pix[CB-1:0]);
                end
            end
        end
    end

    // Reference rectangle walk; limit caps the number of pixels pushed
    function automatic void model_fill(int x0, int y0, int x1, int y1, int c, int limit);
        int xa, xb, ya, yb, n;
        xa = (x0 < x1) ? x0 : x1;
        xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
        if (xb > H_RES - 1) xb = H_RES - 1;
        if (yb > V_RES - 1) yb = V_RES - 1;
        if (xa >= H_RES || ya >= V_RES) return;
        n = 0;
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                if (n < limit) begin
                    exp_q.push_back({XB'(x), YB'(y), CB'(c)});
                    n++;
                end
    endfunction

    // Waits for cmd_ready, then presents the command for exactly one accept edge
    task automatic send_cmd(input int op, input int x0, input int y0, input int x1,
                            input int y1, input int c);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 25000) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 25000) begin
            checks++; failures++;
            $display("FAIL ready_timeout got cmd_ready=%b want 1", cmd_ready);
        end
        cmd_op = 2'(op); cmd_x0 = XB'(x0); cmd_y0 = YB'(y0);
        cmd_x1 = XB'(x1); cmd_y1 = YB'(y1); cmd_colour = CB'(c);
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({plot, plot_x, plot_y, plot_colour, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got plot=%b x=%0d y=%0d c=%h busy=%b want all 0",
                     plot, plot_x, plot_y, plot_colour, busy);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_plot;
        model_fill(3, 5, 3, 5, 'h7FFF, 1);
        send_cmd(0, 3, 5, 0, 0, 'h7FFF);
        @(negedge clock);
        checks++;
        if (plot !== 1'b1) begin
            failures++;
            $display("FAIL plot_latency got plot=%b want 1", plot);
        end
        wait_drain(20);
        $display("test_plot done");
    endtask

    task automatic test_back_to_back;
        int start = plot_total;
        for (int i = 0; i < 4; i++) begin
            model_fill(10 + i, 20 + i, 10 + i, 20 + i, 'h100 + i, 1);
            cmd_op = 2'd0; cmd_x0 = XB'(10 + i); cmd_y0 = YB'(20 + i);
            cmd_colour = CB'('h100 + i); cmd_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (cmd_ready !== 1'b1 || (i > 0 && plot !== 1'b1)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got ready=%b plot=%b want 1/1", i, cmd_ready, plot);
            end
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (plot !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last got plot=%b want 1", plot);
        end
        wait_drain(20);
        checks++;
        if (plot_total - start != 4) begin
            failures++;
            $display("FAIL b2b_count got %0d want 4", plot_total - start);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_plot_oob;
        int start = plot_total;
        send_cmd(0, 160, 0, 0, 0, 'h1234);
        send_cmd(0, 0, 120, 0, 0, 'h1234);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL oob_ready got %b want 1", cmd_ready);
        end
        wait_drain(10);
        checks++;
        if (plot_total != start) begin
            failures++;
            $display("FAIL oob_count got %0d want 0", plot_total - start);
        end
        $display("test_plot_oob done");
    endtask

    task automatic test_fill;
        int busy_cycles = 0;
        int n = 0;
        model_fill(5, 2, 3, 1, 'h2AAA, 1000);
        send_cmd(1, 5, 2, 3, 1, 'h2AAA);
        while (busy === 1'b1 && n < 50) begin
            busy_cycles++;
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (busy_cycles != 6 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_busy got busy_cycles=%0d ready=%b want 6/1", busy_cycles, cmd_ready);
        end
        wait_drain(20);
        $display("test_fill done");
    endtask

    task automatic test_clip;
        int start;
        model_fill(158, 118, 200, 127, 'h0F0F, 1000);
        send_cmd(1, 158, 118, 200, 127, 'h0F0F);
        wait_drain(20);
        start = plot_total;
        send_cmd(1, 170, 0, 180, 5, 'h0F0F);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL clip_empty got busy=%b ready=%b want 0/1", busy, cmd_ready);
        end
        wait_drain(10);
        checks++;
        if (plot_total != start) begin
            failures++;
            $display("FAIL clip_empty_count got %0d want 0", plot_total - start);
        end
        $display("test_clip done");
    endtask

    task automatic test_degenerate;
        int start = plot_total;
        model_fill(7, 7, 7, 7, 'h0055, 1000);
        send_cmd(1, 7, 7, 7, 7, 'h0055);
        wait_drain(10);
        send_cmd(3, 1, 1, 9, 9, 'h0066);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reserved_ready got %b want 1", cmd_ready);
        end
        // abort coinciding with the accept edge must not cut the fill short
        model_fill(2, 3, 3, 3, 'h0077, 1000);
        cmd_abort = 1'b1;
        send_cmd(1, 2, 3, 3, 3, 'h0077);
        cmd_abort = 1'b0;
        wait_drain(10);
        checks++;
        if (plot_total - start != 3) begin
            failures++;
            $display("FAIL degenerate_count got %0d want 3", plot_total - start);
        end
        $display("test_degenerate done");
    endtask

    task automatic test_clear;
        int start = plot_total;
        model_fill(0, 0, H_RES - 1, V_RES - 1, 'h001F, 100000);
        send_cmd(2, 50, 50, 60, 60, 'h001F);
        wait_drain(20000);
        checks++;
        if (plot_total - start != H_RES * V_RES || last_x != 159 || last_y != 119) begin
            failures++;
            $display("FAIL clear got count=%0d last=(%0d,%0d) want 19200 (159,119)",
                     plot_total - start, last_x, last_y);
        end
        $display("test_clear done");
    endtask

    task automatic test_abort(input bit use_reset);
        int start = plot_total;
        model_fill(0, 0, 9, 9, 'h3C3C, 4);
        send_cmd(1, 0, 0, 9, 9, 'h3C3C);
        repeat (3) begin
            @(posedge clock); #1;
        end
        if (use_reset) reset = 1'b1;
        else cmd_abort = 1'b1;
        @(posedge clock); #1;
        cmd_abort = 1'b0;
        reset = 1'b0;
        checks++;
        if (plot !== 1'b0 || cmd_ready !== 1'b1 ||
            (use_reset && (plot_x !== '0 || plot_y !== '0 || busy !== 1'b0))) begin
            failures++;
            $display("FAIL abort_stop(reset=%0d) got plot=%b ready=%b x=%0d y=%0d want 0/1/0/0",
                     use_reset, plot, cmd_ready, plot_x, plot_y);
        end
        wait_drain(20);
        checks++;
        if (plot_total - start != 4) begin
            failures++;
            $display("FAIL abort_count(reset=%0d) got %0d want 4", use_reset, plot_total - start);
        end
        $display("test_abort reset=%0d done", use_reset);
    endtask

    initial begin
        test_reset();
        test_plot();
        test_back_to_back();
        test_plot_oob();
        test_fill();
        test_clip();
        test_degenerate();
        test_clear();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
